leb128_unpack_u32: RTL and testbench

- Registered decoder for unsigned LEB128-encoded 32-bit integers.
- Takes a 5-byte window, least-significant byte first (i0 = first byte on the wire).
- Returns the decoded value and the number of bytes consumed, so the upstream byte aligner can advance.
- Sits after the stream byte aligner in the WASM/LEB128 parsing datapath.

---
 rtl/leb128_pkg.sv | 18 +
 rtl/leb128_len_detect.sv | 25 ++
 rtl/leb128_unpack_u32.sv | 71 +++++++
 tb/tb_leb128_unpack_u32.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/leb128_pkg.sv
// ============================================================================
// leb128_pkg : shared widths and types for the LEB128 u32 unpacker
// Rev 1.0
// ============================================================================
`default_nettype none

package leb128_pkg;

  localparam int LEB_BYTE_W      = 8;
  localparam int LEB_GROUP_W     = 7;
  localparam int LEB_U32_MAX_LEN = 5;

  typedef logic [LEB_BYTE_W-1:0] leb_byte_t;
  typedef logic [2:0]            leb_len_t;

endpackage

`default_nettype wire

// File: rtl/leb128_len_detect.sv
// ============================================================================
// leb128_len_detect : first clear continuation bit among bytes 0..3 -> len
// Rev 1.0
// ============================================================================
`default_nettype none

module leb128_len_detect
  import leb128_pkg::*;
(
  input  logic [3:0] cont,
  output leb_len_t   len
);

  // cont[k] is bit7 of byte k; all four set means byte 4 is forced to be last
  always_comb begin
    len = leb_len_t'(LEB_U32_MAX_LEN);
    if (!cont[0])      len = 3'd1;
    else if (!cont[1]) len = 3'd2;
    else if (!cont[2]) len = 3'd3;
    else if (!cont[3]) len = 3'd4;
  end

endmodule

`default_nettype wire

// File: rtl/leb128_unpack_u32.sv
// ============================================================================
// leb128_unpack_u32 : one-cycle registered unsigned LEB128 -> u32 decoder
// Optional malformed-encoding flag: define LEB128_UNPACK_ERR_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module leb128_unpack_u32
  import leb128_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  leb_byte_t   i0,
  input  leb_byte_t   i1,
  input  leb_byte_t   i2,
  input  leb_byte_t   i3,
  input  leb_byte_t   i4,
  output logic        out_valid,
  output logic [31:0] o,
  output leb_len_t    len,
  output logic        err
);

  leb_len_t    len_c;
  logic [31:0] val_c;
  logic        err_c;

  leb128_len_detect u_len_detect (
    .cont ({i3[7], i2[7], i1[7], i0[7]}),
    .len  (len_c)
  );

  // Groups at or beyond the terminating byte are masked to zero
  always_comb begin
    val_c = '0;
    val_c[LEB_GROUP_W-1:0] = i0[LEB_GROUP_W-1:0];
    if (len_c > 3'd1) val_c[13:7]  = i1[LEB_GROUP_W-1:0];
    if (len_c > 3'd2) val_c[20:14] = i2[LEB_GROUP_W-1:0];
    if (len_c > 3'd3) val_c[27:21] = i3[LEB_GROUP_W-1:0];
    if (len_c > 3'd4) val_c[31:28] = i4[3:0];
  end

`ifdef LEB128_UNPACK_ERR_EN
  // Five-byte form must terminate and carry no bits above bit 31
  assign err_c = (len_c == leb_len_t'(LEB_U32_MAX_LEN)) && (i4[7] || (|i4[6:4]));
`else
  logic unused_i4_hi;
  assign unused_i4_hi = ^i4[7:4];
  assign err_c        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      o         <= '0;
      len       <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o   <= val_c;
        len <= len_c;
        err <= err_c;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_leb128_unpack_u32.sv
// ============================================================================
// tb_leb128_unpack_u32 : model-compared and literal-pinned bench for the decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_leb128_unpack_u32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  i0 = '0, i1 = '0, i2 = '0, i3 = '0, i4 = '0;
  logic        out_valid;
  logic [31:0] o;
  logic [2:0]  len;
  logic        err;

  int checks = 0;
  int failures = 0;

  leb128_unpack_u32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .i0        (i0),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .i4        (i4),
    .out_valid (out_valid),
    .o         (o),
    .len       (len),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference decode straight from the LEB128 rules
  function automatic int ref_len(input logic [39:0] w);
    int n = 5;
    bit found = 0;
    for (int k = 0; k < 4; k++) begin
      if (!found && !w[8*k+7]) begin
        n = k + 1;
        found = 1;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] ref_val(input logic [39:0] w);
    logic [63:0] acc = '0;
    int n = ref_len(w);
    for (int k = 0; k < n; k++)
      acc = acc | (64'(w[8*k +: 7]) << (7*k));
    return acc[31:0];
  endfunction

  function automatic logic ref_err(input logic [39:0] w);
`ifdef LEB128_UNPACK_ERR_EN
    return (ref_len(w) == 5) && (w[39] || (w[38:36] != 3'd0));
`else
    return (w[39] && 1'b0);
`endif
  endfunction

  // Cycle-level model of the output register
  logic        m_init = 1'b0;
  logic        m_valid;
  logic [31:0] m_o;
  logic [2:0]  m_len;
  logic        m_err;

  always @(posedge clk) begin
    logic [39:0] w;
    w = {i4, i3, i2, i1, i0};
    if (rst) begin
      m_init  <= 1'b1;
      m_valid <= 1'b0;
      m_o     <= '0;
      m_len   <= '0;
      m_err   <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_o   <= ref_val(w);
        m_len <= 3'(ref_len(w));
        m_err <= ref_err(w);
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      checks++;
      if (out_valid !== m_valid || o !== m_o || len !== m_len || err !== m_err) begin
        failures++;
        $display("FAIL model t=%0t got v=%b o=%h len=%0d err=%b want v=%b o=%h len=%0d err=%b",
                 $time, out_valid, o, len, err, m_valid, m_o, m_len, m_err);
      end
    end
  end

  task automatic drive(input logic v, input logic [39:0] w);
    @(posedge clk);
    #1;
    in_valid = v;
    {i4, i3, i2, i1, i0} = w;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Wait for the result of the window driven most recently
  task automatic settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset wins over a valid window
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; {i4, i3, i2, i1, i0} = 40'h00_00_00_00_2A;
    @(posedge clk); #1;
    @(negedge clk);
    lit("rst_valid", {31'd0, out_valid}, 32'd0);
    lit("rst_o", o, 32'd0);
    lit("rst_len", {29'd0, len}, 32'd0);
    lit("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    drive(1, 40'h00_00_00_00_00); settle();
    lit("zero_o", o, 32'd0);
    lit("zero_len", {29'd0, len}, 32'd1);
    lit("zero_valid", {31'd0, out_valid}, 32'd1);

    drive(1, 40'h00_FF_FF_FF_2A); settle();
    lit("past_term_o", o, 32'd42);
    lit("past_term_len", {29'd0, len}, 32'd1);

    drive(1, 40'h00_00_26_8E_E5); settle();
    lit("three_o", o, 32'd624485);
    lit("three_len", {29'd0, len}, 32'd3);

    drive(1, 40'h0F_FF_FF_FF_FF); settle();
    lit("max_o", o, 32'hFFFF_FFFF);
    lit("max_len", {29'd0, len}, 32'd5);
    lit("max_err", {31'd0, err}, 32'd0);

    drive(1, 40'h1F_FF_FF_FF_FF); settle();
    lit("ovf_o", o, 32'hFFFF_FFFF);
    lit("ovf_len", {29'd0, len}, 32'd5);
`ifdef LEB128_UNPACK_ERR_EN
    lit("ovf_err", {31'd0, err}, 32'd1);
`else
    lit("ovf_err", {31'd0, err}, 32'd0);
`endif

    drive(1, 40'h8F_FF_FF_FF_FF); settle();
    lit("unterm_o", o, 32'hFFFF_FFFF);
`ifdef LEB128_UNPACK_ERR_EN
    lit("unterm_err", {31'd0, err}, 32'd1);
`else
    lit("unterm_err", {31'd0, err}, 32'd0);
`endif

    drive(1, 40'h55_AA_33_01_80); settle();
    lit("two_o", o, 32'd128);
    lit("two_len", {29'd0, len}, 32'd2);

    drive(1, 40'hF0_7F_FF_FF_FF); settle();
    lit("four_o", o, 32'h0FFF_FFFF);
    lit("four_len", {29'd0, len}, 32'd4);

    // Back-to-back windows
    drive(1, 40'h00_00_00_00_2A);
    drive(1, 40'h00_00_26_8E_E5);
    @(negedge clk);
    lit("b2b_first", o, 32'd42);
    @(negedge clk);
    lit("b2b_second", o, 32'd624485);
    lit("b2b_valid", {31'd0, out_valid}, 32'd1);

    // Hold with in_valid low and junk on the bytes
    drive(0, 40'hFF_FF_FF_FF_FF); settle();
    lit("hold_valid", {31'd0, out_valid}, 32'd0);
    lit("hold_o", o, 32'd624485);
    lit("hold_len", {29'd0, len}, 32'd3);

    drive(1, 40'h12_34_56_78_9A);
    drive(0, 40'h00_00_00_00_00);
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
